// File: rtl/vgm_axi_pkg.sv
// Shared types for the vgm AXI write-channel slave: ID/address/data/length
// types, the AXI response encoding, the slave FSM states and the queued
// write-address entry.
package vgm_axi_pkg;

    typedef logic [3:0]  id_t;
    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;
    typedef logic [3:0]  len_t;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DATA = 2'b01,
        RESP = 2'b10
    } state_e;

    // One accepted AW transfer waiting for its data burst.
    typedef struct packed {
        id_t   id;
        addr_t addr;
        len_t  len;
    } aw_entry_t;

    // Address of beat 'cnt' of an INCR burst; wraps silently modulo 2^32.
    function automatic addr_t beat_addr(input addr_t base, input len_t cnt,
                                        input int unsigned stride);
        return base + (addr_t'(stride) * addr_t'(cnt));
    endfunction

endpackage

// File: rtl/vgm_axi_aw_fifo.sv
// Synchronous FIFO holding accepted write addresses until the data FSM is
// ready for them. DEPTH must be a power of two so the pointers wrap freely.
// A push is ignored when full and a pop is ignored when empty.
module vgm_axi_aw_fifo
    import vgm_axi_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = aw_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t pop_data,
    output logic   full,
    output logic   empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    entry_t         mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           do_push;
    logic           do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage array: written on an accepted push, contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; simultaneous push and pop keep count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vgm_axi_write_slave.sv
// AXI write-channel slave. Write addresses are queued in a small FIFO; the
// FSM takes one address at a time, accepts AWLEN+1 data beats (WLAST is not
// used to delimit the burst), forwards each beat to a registered memory
// write port and then returns a single B response.
//
// Handshakes: a transfer happens on a rising edge where both VALID and READY
// are high; the source holds VALID and its payload stable until then, and
// READY never depends on the same channel's VALID.
//
// Optional protocol checking: define VGM_AXI_WRITE_SLAVE_CHECK_EN to flag a
// WID mismatch or a misplaced WLAST with BRESP=SLVERR. Without it BRESP is
// always OKAY and no comparison logic exists.
module vgm_axi_write_slave
    import vgm_axi_pkg::*;
#(
    parameter int AW_DEPTH    = 2,
    parameter int ADDR_STRIDE = 4
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic [3:0]  AWID,
    input  logic [31:0] AWADDR,
    input  logic [3:0]  AWLEN,
    input  logic        AWVALID,
    output logic        AWREADY,
    input  logic [3:0]  WID,
    input  logic [31:0] WDATA,
    input  logic        WLAST,
    input  logic        WVALID,
    output logic        WREADY,
    output logic [3:0]  BID,
    output logic [1:0]  BRESP,
    output logic        BVALID,
    input  logic        BREADY,
    output logic        mem_wr_en,
    output logic [31:0] mem_wr_addr,
    output logic [31:0] mem_wr_data
);

    // FSM state is kept as a named signal so checkers can bind to it.
    state_e    state;
    state_e    state_next;

    aw_entry_t aw_in;
    aw_entry_t aw_head;
    logic      fifo_full;
    logic      fifo_empty;
    logic      aw_push;
    logic      aw_pop;
    logic      w_fire;
    logic      b_fire;

    id_t       cur_id;
    addr_t     cur_base;
    len_t      cur_len;
    len_t      beat_cnt;
    logic      err;
    resp_e     bresp_code;

    assign aw_in   = '{id: AWID, addr: AWADDR, len: AWLEN};
    assign AWREADY = !fifo_full;
    assign aw_push = AWVALID && AWREADY;
    assign aw_pop  = (state == IDLE) && !fifo_empty;
    assign w_fire  = WVALID && WREADY;
    assign b_fire  = BVALID && BREADY;

    vgm_axi_aw_fifo #(
        .DEPTH   (AW_DEPTH),
        .entry_t (aw_entry_t)
    ) u_aw_fifo (
        .clk       (ACLK),
        .rst       (ARESET),
        .push      (aw_push),
        .push_data (aw_in),
        .pop       (aw_pop),
        .pop_data  (aw_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // FSM state register.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and channel handshake outputs.
    always_comb begin
        state_next = state;
        WREADY     = 1'b0;
        BVALID     = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                WREADY = 1'b1;
                if (w_fire && (beat_cnt == cur_len)) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                BVALID = 1'b1;
                if (BREADY) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Current burst context: loaded from the FIFO head, beat counter advances
    // on each accepted data beat.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            cur_id   <= '0;
            cur_base <= '0;
            cur_len  <= '0;
            beat_cnt <= '0;
        end else if (aw_pop) begin
            cur_id   <= aw_head.id;
            cur_base <= aw_head.addr;
            cur_len  <= aw_head.len;
            beat_cnt <= '0;
        end else if (w_fire) begin
            beat_cnt <= beat_cnt + len_t'(1);
        end
    end

    // Memory write port: one-cycle strobe in the cycle after each beat.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
        end else begin
            mem_wr_en <= w_fire;
            if (w_fire) begin
                mem_wr_addr <= beat_addr(cur_base, beat_cnt, ADDR_STRIDE);
                mem_wr_data <= WDATA;
            end
        end
    end

`ifdef VGM_AXI_WRITE_SLAVE_CHECK_EN
    logic beat_err;

    assign beat_err = (WID != cur_id) || (WLAST != (beat_cnt == cur_len));

    // Sticky per-burst protocol error, cleared when a new burst is loaded.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            err <= 1'b0;
        end else if (aw_pop) begin
            err <= 1'b0;
        end else if (w_fire && beat_err) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_w_fields;

    assign err             = 1'b0;
    assign unused_w_fields = ^{WID, WLAST};
`endif

    // Response payload is only driven while the response is offered.
    always_comb begin
        bresp_code = OKAY;
        BID        = '0;
        if (state == RESP) begin
            BID        = cur_id;
            bresp_code = err ? SLVERR : OKAY;
        end
    end

    assign BRESP = bresp_code;

endmodule

// File: tb/tb_vgm_axi_write_slave.sv
// Directed bench for vgm_axi_write_slave: single beat with exact latency,
// four-beat burst with held response, AW back-pressure, address wrap,
// protocol-error response and reset in the middle of a burst.
module tb_vgm_axi_write_slave;

    logic        ACLK;
    logic        ARESET;
    logic [3:0]  AWID;
    logic [31:0] AWADDR;
    logic [3:0]  AWLEN;
    logic        AWVALID;
    logic        AWREADY;
    logic [3:0]  WID;
    logic [31:0] WDATA;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [3:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic        mem_wr_en;
    logic [31:0] mem_wr_addr;
    logic [31:0] mem_wr_data;

    int checks = 0;
    int errors = 0;

    // Scoreboard: {addr, data} of every expected and observed memory write.
    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];

`ifdef VGM_AXI_WRITE_SLAVE_CHECK_EN
    localparam logic [1:0] ERR_RESP = 2'b10;
`else
    localparam logic [1:0] ERR_RESP = 2'b00;
`endif

    vgm_axi_write_slave #(
        .AW_DEPTH    (2),
        .ADDR_STRIDE (4)
    ) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .AWID        (AWID),
        .AWADDR      (AWADDR),
        .AWLEN       (AWLEN),
        .AWVALID     (AWVALID),
        .AWREADY     (AWREADY),
        .WID         (WID),
        .WDATA       (WDATA),
        .WLAST       (WLAST),
        .WVALID      (WVALID),
        .WREADY      (WREADY),
        .BID         (BID),
        .BRESP       (BRESP),
        .BVALID      (BVALID),
        .BREADY      (BREADY),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data)
    );

    // Clock.
    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    // Memory write monitor, sampled away from the active edge.
    always @(negedge ACLK) begin
        if (!ARESET && mem_wr_en) begin
            got_q.push_back({mem_wr_addr, mem_wr_data});
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len);
        int n;
        n = 0;
        AWID    = id;
        AWADDR  = addr;
        AWLEN   = len;
        AWVALID = 1'b1;
        while (!AWREADY && n < 100) begin
            tick();
            n++;
        end
        check("aw_ready_wait", AWREADY, 1);
        tick();
        AWVALID = 1'b0;
    endtask

    task automatic send_w(input logic [3:0] id, input logic [31:0] data, input logic last);
        int n;
        n = 0;
        WID    = id;
        WDATA  = data;
        WLAST  = last;
        WVALID = 1'b1;
        while (!WREADY && n < 100) begin
            tick();
            n++;
        end
        check("w_ready_wait", WREADY, 1);
        tick();
        WVALID = 1'b0;
    endtask

    // Waits for B, stalls 'hold' cycles with BREADY low, then accepts it.
    task automatic wait_b(input logic [3:0] id, input logic [1:0] resp, input int hold);
        int n;
        n = 0;
        BREADY = 1'b0;
        while (!BVALID && n < 100) begin
            tick();
            n++;
        end
        check("b_valid_wait", BVALID, 1);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("b_valid_held", BVALID, 1);
            check("b_id_held", BID, id);
        end
        check("b_id", BID, id);
        check("b_resp", BRESP, resp);
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_awready"}, AWREADY, 1);
        check({tag, "_wready"}, WREADY, 0);
        check({tag, "_bvalid"}, BVALID, 0);
        check({tag, "_bid"}, BID, 0);
        check({tag, "_bresp"}, BRESP, 0);
        check({tag, "_wr_en"}, mem_wr_en, 0);
        check({tag, "_wr_addr"}, mem_wr_addr, 0);
        check({tag, "_wr_data"}, mem_wr_data, 0);
    endtask

    initial begin
        int idle_b;
        int idle_w;

        ARESET  = 1'b1;
        AWID    = '0;
        AWADDR  = '0;
        AWLEN   = '0;
        AWVALID = 1'b0;
        WID     = '0;
        WDATA   = '0;
        WLAST   = 1'b0;
        WVALID  = 1'b0;
        BREADY  = 1'b0;

        // Reset values.
        tick();
        tick();
        check_reset_outputs("reset");
        ARESET = 1'b0;
        tick();

        // Single beat with exact latency: AW in cycle n, WREADY in n+2,
        // B in the cycle after the final W handshake.
        AWID    = 4'd3;
        AWADDR  = 32'h0000_0100;
        AWLEN   = 4'd0;
        AWVALID = 1'b1;
        WID     = 4'd3;
        WDATA   = 32'hDEAD_BEEF;
        WLAST   = 1'b1;
        WVALID  = 1'b1;
        check("t1_awready", AWREADY, 1);
        check("t1_wready_n0", WREADY, 0);
        tick();
        AWVALID = 1'b0;
        check("t1_wready_n1", WREADY, 0);
        tick();
        check("t1_wready_n2", WREADY, 1);
        tick();
        WVALID = 1'b0;
        check("t1_bvalid", BVALID, 1);
        check("t1_bid", BID, 4'd3);
        check("t1_bresp", BRESP, 2'b00);
        check("t1_wr_en", mem_wr_en, 1);
        check("t1_wr_addr", mem_wr_addr, 32'h0000_0100);
        check("t1_wr_data", mem_wr_data, 32'hDEAD_BEEF);
        check("t1_wready_resp", WREADY, 0);
        exp_q.push_back({32'h0000_0100, 32'hDEAD_BEEF});
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        check("t1_bvalid_done", BVALID, 0);
        check("t1_wr_en_pulse", mem_wr_en, 0);

        // Four-beat burst, response held under back-pressure.
        send_aw(4'd5, 32'h0000_1000, 4'd3);
        for (int i = 0; i < 4; i++) begin
            send_w(4'd5, 32'(i + 1), (i == 3));
        end
        exp_q.push_back({32'h0000_1000, 32'd1});
        exp_q.push_back({32'h0000_1004, 32'd2});
        exp_q.push_back({32'h0000_1008, 32'd3});
        exp_q.push_back({32'h0000_100C, 32'd4});
        wait_b(4'd5, 2'b00, 3);

        // AW back-pressure: one burst in progress plus two queued fills the
        // FIFO, so a fourth address must stall until a burst retires.
        send_aw(4'd1, 32'h0000_0200, 4'd0);
        send_aw(4'd2, 32'h0000_0300, 4'd0);
        send_aw(4'd3, 32'h0000_0400, 4'd0);
        AWID    = 4'd4;
        AWADDR  = 32'h0000_0500;
        AWLEN   = 4'd0;
        AWVALID = 1'b1;
        tick();
        tick();
        check("bp_awready_full", AWREADY, 0);
        send_w(4'd1, 32'hA1, 1'b1);
        check("bp_awready_still_full", AWREADY, 0);
        wait_b(4'd1, 2'b00, 0);
        send_aw(4'd4, 32'h0000_0500, 4'd0);
        send_w(4'd2, 32'hA2, 1'b1);
        wait_b(4'd2, 2'b00, 0);
        send_w(4'd3, 32'hA3, 1'b1);
        wait_b(4'd3, 2'b00, 0);
        send_w(4'd4, 32'hA4, 1'b1);
        wait_b(4'd4, 2'b00, 0);
        exp_q.push_back({32'h0000_0200, 32'hA1});
        exp_q.push_back({32'h0000_0300, 32'hA2});
        exp_q.push_back({32'h0000_0400, 32'hA3});
        exp_q.push_back({32'h0000_0500, 32'hA4});

        // Address wrap past 2^32.
        send_aw(4'd6, 32'hFFFF_FFFC, 4'd1);
        send_w(4'd6, 32'h1111_1111, 1'b0);
        send_w(4'd6, 32'h2222_2222, 1'b1);
        exp_q.push_back({32'hFFFF_FFFC, 32'h1111_1111});
        exp_q.push_back({32'h0000_0000, 32'h2222_2222});
        wait_b(4'd6, 2'b00, 0);

        // WLAST on the wrong beat: both beats still written.
        send_aw(4'd10, 32'h0000_6000, 4'd1);
        send_w(4'd10, 32'h0000_00B0, 1'b1);
        send_w(4'd10, 32'h0000_00B1, 1'b0);
        exp_q.push_back({32'h0000_6000, 32'h0000_00B0});
        exp_q.push_back({32'h0000_6004, 32'h0000_00B1});
        wait_b(4'd10, ERR_RESP, 0);

        // WID mismatch on the last beat.
        send_aw(4'd11, 32'h0000_7000, 4'd1);
        send_w(4'd11, 32'h0000_00C0, 1'b0);
        send_w(4'd12, 32'h0000_00C1, 1'b1);
        exp_q.push_back({32'h0000_7000, 32'h0000_00C0});
        exp_q.push_back({32'h0000_7004, 32'h0000_00C1});
        wait_b(4'd11, ERR_RESP, 0);

        // A clean burst right after an errored one must report OKAY.
        send_aw(4'd13, 32'h0000_8000, 4'd0);
        send_w(4'd13, 32'h0000_00D0, 1'b1);
        exp_q.push_back({32'h0000_8000, 32'h0000_00D0});
        wait_b(4'd13, 2'b00, 0);

        // Reset after 2 of 4 beats with a second address queued.
        send_aw(4'd7, 32'h0000_2000, 4'd3);
        send_aw(4'd8, 32'h0000_3000, 4'd0);
        send_w(4'd7, 32'h0000_00E0, 1'b0);
        send_w(4'd7, 32'h0000_00E1, 1'b0);
        exp_q.push_back({32'h0000_2000, 32'h0000_00E0});
        exp_q.push_back({32'h0000_2004, 32'h0000_00E1});
        tick();
        ARESET = 1'b1;
        #1;
        check_reset_outputs("midrst");
        tick();
        ARESET = 1'b0;
        idle_b = 0;
        idle_w = 0;
        BREADY = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (BVALID) idle_b++;
            if (WREADY) idle_w++;
        end
        BREADY = 1'b0;
        check("midrst_no_b", 32'(idle_b), 0);
        check("midrst_no_stale_aw", 32'(idle_w), 0);
        send_aw(4'd9, 32'h0000_4000, 4'd1);
        send_w(4'd9, 32'h0000_00F0, 1'b0);
        send_w(4'd9, 32'h0000_00F1, 1'b1);
        exp_q.push_back({32'h0000_4000, 32'h0000_00F0});
        exp_q.push_back({32'h0000_4004, 32'h0000_00F1});
        wait_b(4'd9, 2'b00, 0);
        tick();
        tick();

        // Compare every memory write in order.
        check("wr_count", 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("wr_%0d", i), got_q[i], exp_q[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
